// File: rtl/xcvr_spi_master.sv
// Byte-oriented SPI master: TX/RX byte FIFOs around a strobe-paced shifter.
// SCK is derived from cpol and an internal phase bit, so it idles at cpol even while cpol changes.
module xcvr_spi_master #(
    parameter int LOG2_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spiStrobe,
    input  logic [7:0] dataIn,
    input  logic       write,
    input  logic       read,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       miso,
    output logic       mosi,
    output logic       sck,
    output logic       nCs,
    output logic       txDataPresent,
    output logic       txHalfFull,
    output logic       txFull,
    output logic       rxDataPresent,
    output logic       rxHalfFull,
    output logic       rxFull,
    output logic [7:0] dataOut
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0]   FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0]   HALF_CNT = (LOG2_DEPTH+1)'(DEPTH / 2);
    localparam logic [LOG2_DEPTH:0]   CNT_ONE  = {{LOG2_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, XFER} state_t;

    logic [7:0]            tx_mem_q [DEPTH];
    logic [7:0]            tx_mem_d [DEPTH];
    logic [LOG2_DEPTH-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [LOG2_DEPTH:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]            rx_mem_q [DEPTH];
    logic [7:0]            rx_mem_d [DEPTH];
    logic [LOG2_DEPTH-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [LOG2_DEPTH:0]   rx_cnt_q, rx_cnt_d;

    state_t     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [4:0] cnt_q, cnt_d;
    logic       ph_q, ph_d;
    logic       mosi_q, mosi_d;
    logic       ncs_q, ncs_d;

    logic       tx_push, tx_pop, rx_push, rx_wr, rx_pop, load, sample;
    logic [7:0] rx_byte;

    assign tx_push = write && (tx_cnt_q != FULL_CNT);
    assign rx_wr   = rx_push && (rx_cnt_q != FULL_CNT);
    assign rx_pop  = read && (rx_cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        mosi_d     = mosi_q;
        ncs_d      = ncs_q;
        load       = 1'b0;
        rx_push    = 1'b0;
        rx_byte    = rx_shift_q;
        sample     = ~cnt_q[0] ^ cpha;
        case (state_q)
            IDLE: begin
                if (spiStrobe && (tx_cnt_q != '0)) begin
                    load    = 1'b1;
                    ncs_d   = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (spiStrobe) begin
                    if (cnt_q == 5'd16) begin
                        if (tx_cnt_q != '0) begin
                            load = 1'b1;
                        end else begin
                            ncs_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        ph_d  = ~ph_q;
                        cnt_d = cnt_q + 5'd1;
                        // Even count before the toggle means this toggle is a leading edge.
                        if (sample) begin
                            rx_shift_d = {rx_shift_q[6:0], miso};
                        end else begin
                            mosi_d     = tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                        if (cnt_q == 5'd15) begin
                            rx_push = 1'b1;
                            rx_byte = sample ? {rx_shift_q[6:0], miso} : rx_shift_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // With cpha=0 bit 7 goes out at load, so the shifter is pre-advanced by one.
        if (load) begin
            tx_shift_d = cpha ? tx_mem_q[tx_rd_ptr_q] : {tx_mem_q[tx_rd_ptr_q][6:0], 1'b0};
            if (!cpha) begin
                mosi_d = tx_mem_q[tx_rd_ptr_q][7];
            end
            rx_shift_d = '0;
            cnt_d      = '0;
            ph_d       = 1'b0;
        end
    end

    assign tx_pop = load;

    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_ptr_q] = dataIn;
            tx_wr_ptr_d           = tx_wr_ptr_q + PTR_ONE;
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_wr) begin
            rx_mem_d[rx_wr_ptr_q] = rx_byte;
            rx_wr_ptr_d           = rx_wr_ptr_q + PTR_ONE;
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
        end
        case ({rx_wr, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_mem_q    <= '{default: '0};
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            ph_q        <= 1'b0;
            mosi_q      <= 1'b0;
            ncs_q       <= 1'b1;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_mem_q    <= rx_mem_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            mosi_q      <= mosi_d;
            ncs_q       <= ncs_d;
        end
    end

    assign mosi          = mosi_q;
    assign sck           = cpol ^ ph_q;
    assign nCs           = ncs_q;
    assign txDataPresent = (tx_cnt_q != '0) || (state_q == XFER);
    assign txHalfFull    = tx_cnt_q >= HALF_CNT;
    assign txFull        = tx_cnt_q == FULL_CNT;
    assign rxDataPresent = rx_cnt_q != '0;
    assign rxHalfFull    = rx_cnt_q >= HALF_CNT;
    assign rxFull        = rx_cnt_q == FULL_CNT;
    assign dataOut       = rx_mem_q[rx_rd_ptr_q];

endmodule

// File: tb/tb_xcvr_spi_master.sv
// Scoreboard bench for xcvr_spi_master: expected MOSI frames and RX bytes are queued at
// stimulus time and popped by monitors watching the SPI pins and the RX read port.
module tb_xcvr_spi_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spiStrobe = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       miso;
    logic       mosi, sck, nCs;
    logic       txDataPresent, txHalfFull, txFull;
    logic       rxDataPresent, rxHalfFull, rxFull;
    logic [7:0] dataOut;

    logic       loopback = 1'b0;
    logic       slave_miso = 1'b0;
    logic       strobe_en = 1'b0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] slave_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int ncs_rises = 0;

    assign miso = loopback ? mosi : slave_miso;

    xcvr_spi_master #(.LOG2_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .spiStrobe(spiStrobe), .dataIn(dataIn),
        .write(write), .read(read), .cpol(cpol), .cpha(cpha), .miso(miso),
        .mosi(mosi), .sck(sck), .nCs(nCs),
        .txDataPresent(txDataPresent), .txHalfFull(txHalfFull), .txFull(txFull),
        .rxDataPresent(rxDataPresent), .rxHalfFull(rxHalfFull), .rxFull(rxFull),
        .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // Strobe every 8 clocks when enabled.
    initial begin
        forever begin
            repeat (7) @(posedge clk);
            #1 spiStrobe = strobe_en;
            @(posedge clk);
            #1 spiStrobe = 1'b0;
        end
    end

    // MOSI monitor: shifts mosi on the sampling edge implied by cpol/cpha.
    logic [7:0] mon_sh = 8'h00;
    int         mon_bits = 0;
    always @(sck) begin
        if (nCs === 1'b0 && sck === ~(cpol ^ cpha)) begin
            mon_sh = {mon_sh[6:0], mosi};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_tx_q.size() == 0) fail("mosi_unexpected_frame", mon_sh);
                else check("mosi_frame", mon_sh, exp_tx_q.pop_front());
            end
        end
    end

    always @(posedge nCs) begin
        ncs_rises++;
        mon_bits = 0;
    end

    // RX monitor: every accepted read is compared against the next expected byte.
    always @(negedge clk) begin
        if (read === 1'b1 && rxDataPresent === 1'b1) begin
            if (exp_rx_q.size() == 0) fail("rx_unexpected_byte", dataOut);
            else check("rx_byte", dataOut, exp_rx_q.pop_front());
        end
    end

    // Mode-0 slave: presents bit 7 at nCs fall, shifts on each trailing (falling) edge.
    logic [7:0] sl_sh = 8'h00;
    int         sl_cnt = 0;
    always @(negedge nCs) begin
        if (!loopback) begin
            sl_sh = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            sl_cnt = 0;
            slave_miso = sl_sh[7];
        end
    end
    always @(negedge sck) begin
        if (!loopback && nCs === 1'b0) begin
            sl_cnt++;
            if (sl_cnt == 8) begin
                sl_cnt = 0;
                sl_sh = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            end else begin
                sl_sh = {sl_sh[6:0], 1'b0};
            end
            slave_miso = sl_sh[7];
        end
    end

    task automatic wr(input logic [7:0] b);
        @(posedge clk);
        #1 dataIn = b; write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
    endtask

    task automatic rd();
        @(posedge clk);
        #1 read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && txDataPresent; i++) @(posedge clk);
        #1;
        if (txDataPresent) fail("wait_idle_timeout", i);
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] flags();
        return {txDataPresent, txHalfFull, txFull, rxDataPresent, rxHalfFull, rxFull};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0;
        #12;
        check("reset_ncs", nCs, 1'b1);
        check("reset_sck", sck, 1'b0);
        check("reset_mosi", mosi, 1'b0);
        check("reset_flags", flags(), 6'b0);
        check("reset_dataout", dataOut, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;

        // Mode 0, slave answers 0x3C.
        strobe_en = 1'b1;
        slave_q.push_back(8'h3C);
        exp_tx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        wr(8'hA5);
        check("busy_after_write", txDataPresent, 1'b1);
        wait_idle(2000);
        check("m0_rx_present", rxDataPresent, 1'b1);
        check("m0_ncs_idle", nCs, 1'b1);
        rd();
        check("m0_rx_empty_after_read", rxDataPresent, 1'b0);

        // Three back-to-back bytes with no nCs gap.
        slave_q.push_back(8'h11); slave_q.push_back(8'h22); slave_q.push_back(8'h33);
        exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h02); exp_tx_q.push_back(8'h03);
        exp_rx_q.push_back(8'h11); exp_rx_q.push_back(8'h22); exp_rx_q.push_back(8'h33);
        rises0 = ncs_rises;
        wr(8'h01); wr(8'h02); wr(8'h03);
        wait_idle(4000);
        check("b2b_ncs_rises", ncs_rises - rises0, 1);
        check("b2b_tx_present", txDataPresent, 1'b0);
        check("b2b_tx_all_sent", exp_tx_q.size(), 0);
        rd(); rd(); rd();
        check("b2b_rx_empty", rxDataPresent, 1'b0);

        // Modes 1..3 in loopback.
        loopback = 1'b1;
        for (int m = 1; m < 4; m++) begin
            @(posedge clk);
            #1 {cpol, cpha} = m[1:0];
            #1 check("mode_idle_sck", sck, cpol);
            exp_tx_q.push_back(8'h81);
            exp_rx_q.push_back(8'h81);
            wr(8'h81);
            wait_idle(2000);
            check("mode_end_sck", sck, cpol);
            rd();
        end
        check("modes_rx_empty", rxDataPresent, 1'b0);

        // Fill TX with strobes stopped, then loopback 17 frames into a 16-deep RX.
        @(posedge clk);
        #1 {cpol, cpha} = 2'b00;
        strobe_en = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i);
            wr(b);
            if (i < 16) begin
                exp_tx_q.push_back(b);
                exp_rx_q.push_back(b);
            end
            if (i == 6)  check("tx_half_7", txHalfFull, 1'b0);
            if (i == 7)  check("tx_half_8", txHalfFull, 1'b1);
            if (i == 14) check("tx_full_15", txFull, 1'b0);
            if (i == 15) check("tx_full_16", txFull, 1'b1);
        end
        check("tx_full_after_17", txFull, 1'b1);
        check("ncs_no_strobe", nCs, 1'b1);
        strobe_en = 1'b1;
        wait_idle(8000);
        check("fill_tx_all_sent", exp_tx_q.size(), 0);
        check("rx_full_16", {rxHalfFull, rxFull}, 2'b11);
        exp_tx_q.push_back(8'h77);
        wr(8'h77);
        wait_idle(2000);
        check("frame17_sent", exp_tx_q.size(), 0);
        check("rx_full_after_17", rxFull, 1'b1);
        for (int i = 0; i < 16; i++) rd();
        check("rx_drained_flags", flags(), 6'b0);

        // Reset in the middle of a frame.
        wr(8'h5A);
        repeat (40) @(posedge clk);
        check("mid_frame_ncs_low", nCs, 1'b0);
        #3 rst = 1'b0;
        #1;
        check("abort_ncs", nCs, 1'b1);
        check("abort_sck", sck, 1'b0);
        check("abort_flags", flags(), 6'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_tx_q.push_back(8'hC3);
        exp_rx_q.push_back(8'hC3);
        wr(8'hC3);
        wait_idle(2000);
        check("post_reset_rx_present", rxDataPresent, 1'b1);
        rd();
        check("post_reset_rx_empty", rxDataPresent, 1'b0);
        check("exp_rx_consumed", exp_rx_q.size(), 0);
        check("exp_tx_consumed", exp_tx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
